rx_fifo: RTL and testbench
==========================

# rx_fifo

Receive-side buffer that sits directly downstream of the UART receive engine. It captures each completed character (data plus parity, framing and overrun flags) when the engine raises `rxrdy`. It acknowledges the engine with a one-cycle `read` pulse and queues the character in a circular FIFO. The PicoBlaze port logic then drains that FIFO at its own pace, so bursts of serial data are not lost between processor reads.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rxrdy`  in  1  character-ready flag from the receive engine.
- `rx_out`  in  8  received character from the receive engine.
- `perr`  in  1  parity error of the current character.
- `ferr`  in  1  framing error of the current character.
- `ovf`  in  1  engine overrun flag of the current character.
- `read`  out  1  registered one-cycle acknowledge to the receive engine.
- `pop`  in  1  processor read strobe; removes the head entry.
- `clr_err`  in  1  clears the sticky error register.
- `dout`  out  8  head-entry data (show-ahead).
- `dout_err`  out  3  head-entry {ovf, ferr, perr}.
- `empty`  out  1  FIFO holds 0 entries.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- `count`  out  DEPTH_LOG2+1  current occupancy.
- `err_sticky`  out  4  {drop, ovf, ferr, perr}, OR-accumulated.

## Operation
- **Capture FSM, two states.**
  - `IDLE`: when `rxrdy`=1 is sampled, do the following on that edge:
    - If not full, write {ovf, ferr, perr, rx_out} at the write pointer.
    - If full, discard the character and set the sticky `drop` bit.
    - In both cases, set `read`=1 for exactly the next cycle and go to `WAIT`.
  - `WAIT`: `read`=0. Return to `IDLE` only after `rxrdy` is sampled 0. This guarantees one capture per character even if the engine holds `rxrdy` for several cycles.
- **Pointers.** Write and read pointers are DEPTH_LOG2 bits wide and wrap modulo depth. `count` is a separate up/down counter: +1 on push only, −1 on pop only, unchanged on push+pop.
- **Pop.**
  - When `empty`=1, `pop` is ignored: no pointer or count change.
  - When `empty`=1 and a capture happens on the same edge, the pop is still ignored and the new entry stays.
- **Push while full.** Capture and `pop` on the same edge succeed together. The pop frees the slot, the write lands, and `count` stays at depth.
- **Sticky errors.**
  - `err_sticky` ORs in {0, ovf, ferr, perr} on each successful capture, and sets `drop` on each discarded capture.
  - `clr_err` zeroes the register. If a set event occurs on the same edge, the set wins.
- **Outputs.**
  - `dout`/`dout_err` always reflect memory at the read pointer.
  - Their value is don't-care when `empty`=1; the bench must not check it.
- **Reset (async).** All outputs and state are forced as follows:
  - FSM to `IDLE`; pointers 0; `count`=0.
  - `empty`=1, `full`=0, `read`=0, `err_sticky`=0.
  - `dout`/`dout_err` undefined.
  - A character pending at reset is not captured until `rxrdy` is next sampled high in `IDLE`.

## Timing
- `rxrdy` sampled high at edge E: entry written, `count`/`empty`/`full` updated, and `read` goes high, all at E. `read` falls at E+1.
- The earliest next capture is the first edge after `rxrdy` is sampled low.
- `pop` sampled at edge P: the read pointer advances at P, and the new head is visible on `dout` immediately after P.
- Flags (`empty`, `full`) and `count` are registered. They are never combinational from `pop` or `rxrdy`.
- Throughput is one capture per `rxrdy` pulse and one pop per cycle.

## Configuration
- Macro: `RX_FIFO_ERR_TAG_EN`.
- **Defined:** each entry is 11 bits, and `dout_err` presents the head entry's {ovf, ferr, perr}.
- **Undefined:** entries are 8 bits and `dout_err` is tied to 3'b000. `err_sticky` behaves identically in both builds.

## Test plan
- **Single character:** reset, then `rxrdy`=1 for 3 cycles with `rx_out`=8'hA5.
  - Required: exactly one `read` pulse; `count`=1; `empty`=0; `dout`=8'hA5.
  - After `pop`: `empty`=1, `count`=0.
- **Fill and overfill:** 17 characters 8'h00..8'h10, no pops.
  - Required: `full`=1 at count 16; the 17th character is dropped with `read` still pulsed; `err_sticky`[3]=1.
  - Popping 16 times returns 8'h00..8'h0F in order.
- **Push+pop while full:** with the FIFO full, a capture of 8'h55 and a `pop` on the same edge.
  - Required: `count` stays 16; `err_sticky`[3]=0; 8'h55 is read last.
- **Error tagging (macro defined):** a character 8'h3C with `ferr`=1.
  - Required: `dout_err`=3'b010 at the head; `err_sticky`=4'b0010.
  - `clr_err` on the same edge as a `perr`=1 capture leaves `err_sticky`=4'b0001.
- **Pop when empty, and reset mid-operation:** `pop` on an empty FIFO leaves `count`=0 and the pointers unchanged.
  - Asserting `reset` during `WAIT` with 5 entries queued gives `count`=0, `empty`=1 and `read`=0 immediately (asynchronous).

Source files
------------

// File: rtl/rx_fifo.sv
// rx_fifo: receive-side character buffer between the UART receive engine and
// the PicoBlaze port logic. Captures one character per rxrdy assertion, acks
// the engine with a one-cycle read pulse, and queues data in a circular FIFO.
// Optional build macro RX_FIFO_ERR_TAG_EN stores {ovf, ferr, perr} with each
// entry and presents it on dout_err; without it dout_err is tied to zero.
module rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxrdy,
    input  logic [7:0]            rx_out,
    input  logic                  perr,
    input  logic                  ferr,
    input  logic                  ovf,
    output logic                  read,
    input  logic                  pop,
    input  logic                  clr_err,
    output logic [7:0]            dout,
    output logic [2:0]            dout_err,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic [3:0]            err_sticky
);

`ifdef RX_FIFO_ERR_TAG_EN
    localparam int ENTRY_W = 11;
`else
    localparam int ENTRY_W = 8;
`endif
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t                 state;
    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic                   capture;
    logic                   do_pop;
    logic                   push;
    logic                   drop;
    logic [DEPTH_LOG2:0]    count_next;
    logic [3:0]             err_set;
    logic [ENTRY_W-1:0]     wr_entry;

`ifdef RX_FIFO_ERR_TAG_EN
    assign wr_entry = {ovf, ferr, perr, rx_out};
    assign dout     = mem[rd_ptr][7:0];
    assign dout_err = mem[rd_ptr][10:8];
`else
    assign wr_entry = rx_out;
    assign dout     = mem[rd_ptr];
    assign dout_err = 3'b000;
`endif

    // Decide this edge's push/pop/drop; a pop on a full FIFO frees the slot a
    // simultaneous capture needs, so both succeed and occupancy holds.
    always_comb begin
        capture    = (state == IDLE) && rxrdy;
        do_pop     = pop && !empty;
        push       = capture && (!full || do_pop);
        drop       = capture && full && !do_pop;
        count_next = count;
        if (push && !do_pop) begin
            count_next = count + CNT_ONE;
        end else if (do_pop && !push) begin
            count_next = count - CNT_ONE;
        end
        err_set = 4'b0000;
        if (push) begin
            err_set = {1'b0, ovf, ferr, perr};
        end else if (drop) begin
            err_set = 4'b1000;
        end
    end

    // Capture handshake, pointers, registered flags and sticky error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            read       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            err_sticky <= 4'b0000;
        end else begin
            read <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxrdy) begin
                        read  <= 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!rxrdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count      <= count_next;
            empty      <= (count_next == '0);
            full       <= count_next[DEPTH_LOG2];
            err_sticky <= (clr_err ? 4'b0000 : err_sticky) | err_set;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_rx_fifo.sv
// tb_rx_fifo: directed bench for rx_fifo with a queue-based reference model
// and a per-cycle compare process, plus literal expectations per scenario.
module tb_rx_fifo;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 rxrdy = 1'b0;
    logic [7:0]           rx_out = 8'h00;
    logic                 perr = 1'b0;
    logic                 ferr = 1'b0;
    logic                 ovf = 1'b0;
    logic                 pop = 1'b0;
    logic                 clr_err = 1'b0;
    logic                 read;
    logic [7:0]           dout;
    logic [2:0]           dout_err;
    logic                 empty;
    logic                 full;
    logic [DEPTH_LOG2:0]  count;
    logic [3:0]           err_sticky;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [10:0] mq[$];
    logic [3:0]  m_sticky;
    bit          m_armed;
    bit          m_read;
    bit          model_valid = 1'b0;

    rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxrdy      (rxrdy),
        .rx_out     (rx_out),
        .perr       (perr),
        .ferr       (ferr),
        .ovf        (ovf),
        .read       (read),
        .pop        (pop),
        .clr_err    (clr_err),
        .dout       (dout),
        .dout_err   (dout_err),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .err_sticky (err_sticky)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: one capture per rxrdy assertion, FIFO as a queue, sticky ORing
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_sticky = 4'b0000;
            m_armed  = 1'b1;
            m_read   = 1'b0;
        end else begin
            bit       take;
            bit       popped;
            int       size_before;
            logic [3:0] base;
            size_before = mq.size();
            take   = m_armed && rxrdy;
            popped = pop && (size_before != 0);
            base   = clr_err ? 4'b0000 : m_sticky;
            if (popped) void'(mq.pop_front());
            if (take) begin
                if (size_before < DEPTH || popped) begin
                    mq.push_back({ovf, ferr, perr, rx_out});
                    base = base | {1'b0, ovf, ferr, perr};
                end else begin
                    base = base | 4'b1000;
                end
            end
            m_sticky = base;
            m_read   = take;
            if (m_armed) m_armed = !rxrdy;
            else         m_armed = !rxrdy;
        end
    end

    // Compare DUT against model every cycle, away from the rising edge
    always @(negedge clk) begin
        if (model_valid && !reset) begin
            checkOutput("count", 32'(count), 32'(mq.size()));
            checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
            checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
            checkOutput("read", 32'(read), 32'(m_read));
            checkOutput("err_sticky", 32'(err_sticky), 32'(m_sticky));
            if (mq.size() != 0) begin
                checkOutput("dout", 32'(dout), 32'(mq[0][7:0]));
`ifdef RX_FIFO_ERR_TAG_EN
                checkOutput("dout_err", 32'(dout_err), 32'(mq[0][10:8]));
`else
                checkOutput("dout_err", 32'(dout_err), 32'h0);
`endif
            end
        end
    end

    // Drive one cycle of inputs; returns at the following falling edge
    task automatic applyStimulus(input logic r, input logic [7:0] d, input logic [2:0] e,
                                 input logic p, input logic c);
        rxrdy   = r;
        rx_out  = d;
        ovf     = e[2];
        ferr    = e[1];
        perr    = e[0];
        pop     = p;
        clr_err = c;
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        #1 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pushChar(input logic [7:0] d, input logic [2:0] e);
        applyStimulus(1'b1, d, e, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        @(negedge clk);
        reset = 1'b0;
        model_valid = 1'b1;
        checkOutput("rst_count", 32'(count), 32'h0);
        checkOutput("rst_empty", 32'(empty), 32'h1);
        checkOutput("rst_full", 32'(full), 32'h0);
        checkOutput("rst_read", 32'(read), 32'h0);
        checkOutput("rst_sticky", 32'(err_sticky), 32'h0);

        // Single character held for three cycles
        applyStimulus(1'b1, 8'hA5, 3'b000, 1'b0, 1'b0);
        checkOutput("sc_read1", 32'(read), 32'h1);
        applyStimulus(1'b1, 8'hA5, 3'b000, 1'b0, 1'b0);
        checkOutput("sc_read2", 32'(read), 32'h0);
        applyStimulus(1'b1, 8'hA5, 3'b000, 1'b0, 1'b0);
        checkOutput("sc_read3", 32'(read), 32'h0);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        checkOutput("sc_count", 32'(count), 32'h1);
        checkOutput("sc_empty", 32'(empty), 32'h0);
        checkOutput("sc_dout", 32'(dout), 32'hA5);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        checkOutput("sc_pop_empty", 32'(empty), 32'h1);
        checkOutput("sc_pop_count", 32'(count), 32'h0);

        // Fill and overfill
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'(i), 3'b000, 1'b0, 1'b0);
            if (i == 16) begin
                checkOutput("of_read", 32'(read), 32'h1);
                checkOutput("of_count", 32'(count), 32'd16);
                checkOutput("of_drop", 32'(err_sticky[3]), 32'h1);
            end
            applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
            if (i == 15) begin
                checkOutput("fill_full", 32'(full), 32'h1);
                checkOutput("fill_count", 32'(count), 32'd16);
            end
        end
        for (int i = 0; i < 16; i++) begin
            checkOutput("drain_order", 32'(dout), 32'(i));
            applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        end
        checkOutput("drain_empty", 32'(empty), 32'h1);

        // Push and pop on the same edge while full
        doReset();
        for (int i = 0; i < 16; i++) pushChar(8'h80 + 8'(i), 3'b000);
        applyStimulus(1'b1, 8'h55, 3'b000, 1'b1, 1'b0);
        checkOutput("pf_count", 32'(count), 32'd16);
        checkOutput("pf_full", 32'(full), 32'h1);
        checkOutput("pf_drop", 32'(err_sticky[3]), 32'h0);
        checkOutput("pf_head", 32'(dout), 32'h81);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        checkOutput("pf_last", 32'(dout), 32'h55);
        checkOutput("pf_last_count", 32'(count), 32'h1);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);

        // Error tagging and clear-vs-set priority
        doReset();
        pushChar(8'h3C, 3'b010);
        checkOutput("et_sticky", 32'(err_sticky), 32'h2);
        checkOutput("et_dout", 32'(dout), 32'h3C);
`ifdef RX_FIFO_ERR_TAG_EN
        checkOutput("et_dout_err", 32'(dout_err), 32'h2);
`else
        checkOutput("et_dout_err", 32'(dout_err), 32'h0);
`endif
        applyStimulus(1'b1, 8'h44, 3'b001, 1'b0, 1'b1);
        checkOutput("et_clr_set", 32'(err_sticky), 32'h1);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b1);
        checkOutput("et_clr", 32'(err_sticky), 32'h0);

        // Pop on empty, capture with pop on empty, then reset during WAIT
        doReset();
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        checkOutput("pe_count", 32'(count), 32'h0);
        pushChar(8'h11, 3'b000);
        pushChar(8'h22, 3'b000);
        checkOutput("pe_head", 32'(dout), 32'h11);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        checkOutput("pe_next", 32'(dout), 32'h22);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h33, 3'b000, 1'b1, 1'b0);
        checkOutput("pe_cap_count", 32'(count), 32'h1);
        checkOutput("pe_cap_dout", 32'(dout), 32'h33);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);

        doReset();
        for (int i = 0; i < 4; i++) pushChar(8'hC0 + 8'(i), 3'b100);
        applyStimulus(1'b1, 8'hC4, 3'b000, 1'b0, 1'b0);
        checkOutput("mr_count5", 32'(count), 32'd5);
        #2 reset = 1'b1;
        #1;
        checkOutput("mr_count", 32'(count), 32'h0);
        checkOutput("mr_empty", 32'(empty), 32'h1);
        checkOutput("mr_read", 32'(read), 32'h0);
        checkOutput("mr_sticky", 32'(err_sticky), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 8'hC4, 3'b000, 1'b0, 1'b0);
        checkOutput("mr_recapture", 32'(count), 32'h1);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
